// File: rtl/time_entry_countdown_pkg.sv
// Shared microwave types: FSM states, BCD digit type and digit limit.
package microondas_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    RUN,
    PAUSE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/time_entry_countdown_if.sv
// Keypad encoder link: BCD digit, active-low valid strobe, active-low enable back.
interface time_entry_countdown_if;
  import microondas_pkg::*;

  bcd_t digit;
  logic dv;
  logic key_en_n;

  modport master (output digit, output dv, input key_en_n);
  modport slave  (input digit, input dv, output key_en_n);

endinterface

// File: rtl/time_entry_countdown_bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement by one second.
module bcd_mmss_dec
  import microondas_pkg::*;
#(
  parameter bcd_t SEC_WRAP_TENS = 4'd5
) (
  input  bcd_t min_t,
  input  bcd_t min_o,
  input  bcd_t sec_t,
  input  bcd_t sec_o,
  output bcd_t dec_min_t,
  output bcd_t dec_min_o,
  output bcd_t dec_sec_t,
  output bcd_t dec_sec_o,
  output logic is_zero
);

  // Borrow ripples from seconds ones up through minutes tens.
  always_comb begin
    dec_min_t = min_t;
    dec_min_o = min_o;
    dec_sec_t = sec_t;
    dec_sec_o = sec_o;
    if (sec_o != 4'd0) begin
      dec_sec_o = sec_o - 4'd1;
    end else if (sec_t != 4'd0) begin
      dec_sec_t = sec_t - 4'd1;
      dec_sec_o = BCD_MAX;
    end else if (min_o != 4'd0) begin
      dec_min_o = min_o - 4'd1;
      dec_sec_t = SEC_WRAP_TENS;
      dec_sec_o = BCD_MAX;
    end else if (min_t != 4'd0) begin
      dec_min_t = min_t - 4'd1;
      dec_min_o = BCD_MAX;
      dec_sec_t = SEC_WRAP_TENS;
      dec_sec_o = BCD_MAX;
    end
  end

  assign is_zero = ({dec_min_t, dec_min_o, dec_sec_t, dec_sec_o} == 16'h0000);

endmodule

// File: rtl/time_entry_countdown.sv
// Microwave keypad time entry (MM:SS shift register) and 1 Hz countdown FSM.
module time_entry_countdown
  import microondas_pkg::*;
#(
  parameter bcd_t SEC_WRAP_TENS = 4'd5
) (
  input  logic                        clk,
  input  logic                        rst,
  time_entry_countdown_if.slave       keypad,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        clear,
  input  logic                        tick,
  output bcd_t                        min_t,
  output bcd_t                        min_o,
  output bcd_t                        sec_t,
  output bcd_t                        sec_o,
  output logic                        running,
  output logic                        done
);

  state_t state, state_nxt;
  logic   dv_q;
  logic   key_hit;
  logic   time_zero;
  logic   done_nxt;
  bcd_t   min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;
  bcd_t   dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
  logic   dec_zero;

  assign key_hit   = !keypad.dv && dv_q;
  assign time_zero = ({min_t, min_o, sec_t, sec_o} == 16'h0000);

  bcd_mmss_dec #(.SEC_WRAP_TENS(SEC_WRAP_TENS)) u_dec (
    .min_t     (min_t),
    .min_o     (min_o),
    .sec_t     (sec_t),
    .sec_o     (sec_o),
    .dec_min_t (dec_min_t),
    .dec_min_o (dec_min_o),
    .dec_sec_t (dec_sec_t),
    .dec_sec_o (dec_sec_o),
    .is_zero   (dec_zero)
  );

  // Next state and next display digits; one action per cycle, clear > pause > start.
  always_comb begin
    state_nxt = state;
    min_t_nxt = min_t;
    min_o_nxt = min_o;
    sec_t_nxt = sec_t;
    sec_o_nxt = sec_o;
    done_nxt  = 1'b0;
    case (state)
      ENTRY: begin
        if (clear) begin
          {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
        end else if (start) begin
          if (!time_zero) state_nxt = RUN;
        end else if (key_hit && bcd_valid(keypad.digit)) begin
          min_t_nxt = min_o;
          min_o_nxt = sec_t;
          sec_t_nxt = sec_o;
          sec_o_nxt = keypad.digit;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = ENTRY;
          {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          min_t_nxt = dec_min_t;
          min_o_nxt = dec_min_o;
          sec_t_nxt = dec_sec_t;
          sec_o_nxt = dec_sec_o;
          if (dec_zero) begin
            state_nxt = ENTRY;
            done_nxt  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_nxt = ENTRY;
          {min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} = '0;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  // State, digit register, key edge history and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ENTRY;
      dv_q            <= 1'b1;
      {min_t, min_o, sec_t, sec_o} <= '0;
      running         <= 1'b0;
      done            <= 1'b0;
      keypad.key_en_n <= 1'b0;
    end else begin
      state           <= state_nxt;
      dv_q            <= keypad.dv;
      min_t           <= min_t_nxt;
      min_o           <= min_o_nxt;
      sec_t           <= sec_t_nxt;
      sec_o           <= sec_o_nxt;
      running         <= (state_nxt == RUN);
      done            <= done_nxt;
      keypad.key_en_n <= (state_nxt != ENTRY);
    end
  end

endmodule

// File: tb/tb_time_entry_countdown.sv
// Directed self-checking bench for time_entry_countdown.
module tb_time_entry_countdown;
  import microondas_pkg::*;

  logic clk = 1'b0;
  logic rst, start, pause, clear, tick;
  bcd_t min_t, min_o, sec_t, sec_o;
  logic running, done;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  time_entry_countdown_if kp ();

  time_entry_countdown #(.SEC_WRAP_TENS(4'd5)) dut (
    .clk     (clk),
    .rst     (rst),
    .keypad  (kp),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .tick    (tick),
    .min_t   (min_t),
    .min_o   (min_o),
    .sec_t   (sec_t),
    .sec_o   (sec_o),
    .running (running),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  task automatic press(input logic [3:0] d);
    kp.digit = d;
    kp.dv    = 1'b0;
    cyc(5);
    kp.dv    = 1'b1;
    cyc(2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0;
    kp.dv = 1'b1; kp.digit = 4'd0;
    cyc(2);
    rst = 1'b0;
    check("rst_time", disp(), 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_key_en_n", {15'd0, kp.key_en_n}, 16'd0);
    cyc(1);

    // Key entry, held key, invalid digit
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_0130", disp(), 16'h0130);
    kp.digit = 4'd7; kp.dv = 1'b0;
    cyc(20);
    kp.dv = 1'b1;
    cyc(2);
    check("held_key_one_shift", disp(), 16'h1307);
    press(4'd12);
    check("invalid_digit", disp(), 16'h1307);
    pulse_clear();
    check("clear_entry", disp(), 16'h0000);

    // 31 back-to-back ticks from 01:30
    press(4'd1); press(4'd3); press(4'd0);
    pulse_start();
    check("start_running", {15'd0, running}, 16'd1);
    check("start_key_en_n", {15'd0, kp.key_en_n}, 16'd1);
    tick = 1'b1;
    for (int i = 0; i < 31; i++) begin
      cyc(1);
      check("run_running", {15'd0, running}, 16'd1);
      if (i == 0) check("first_tick", disp(), 16'h0129);
      if (i == 29) check("tick_0100", disp(), 16'h0100);
    end
    tick = 1'b0;
    check("minute_borrow_0059", disp(), 16'h0059);
    pulse_clear();
    check("clear_run_time", disp(), 16'h0000);
    check("clear_run_running", {15'd0, running}, 16'd0);

    // Completion
    press(4'd2);
    pulse_start();
    pulse_tick();
    check("done_0001", disp(), 16'h0001);
    check("done_early", {15'd0, done}, 16'd0);
    pulse_tick();
    check("done_0000", disp(), 16'h0000);
    check("done_pulse", {15'd0, done}, 16'd1);
    check("done_running", {15'd0, running}, 16'd0);
    check("done_key_en_n", {15'd0, kp.key_en_n}, 16'd0);
    cyc(1);
    check("done_one_cycle", {15'd0, done}, 16'd0);

    // Pause with simultaneous tick, ignored ticks/keys, resume
    press(4'd4); press(4'd5);
    pulse_start();
    pause = 1'b1; tick = 1'b1;
    cyc(1);
    pause = 1'b0; tick = 1'b0;
    check("pause_time", disp(), 16'h0045);
    check("pause_running", {15'd0, running}, 16'd0);
    check("pause_key_en_n", {15'd0, kp.key_en_n}, 16'd1);
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    press(4'd9);
    check("pause_ignores", disp(), 16'h0045);
    pulse_start();
    check("resume_running", {15'd0, running}, 16'd1);
    pulse_tick();
    check("resume_tick", disp(), 16'h0044);
    pulse_clear();

    // Start refused at zero; start wins over same-cycle key
    pulse_start();
    check("start_zero_running", {15'd0, running}, 16'd0);
    check("start_zero_key_en_n", {15'd0, kp.key_en_n}, 16'd0);
    press(4'd5);
    kp.digit = 4'd3; kp.dv = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_key_running", {15'd0, running}, 16'd1);
    check("start_key_time", disp(), 16'h0005);
    cyc(3);
    kp.dv = 1'b1;
    cyc(2);
    check("run_key_ignored", disp(), 16'h0005);
    pulse_clear();

    // Ten-minute borrow
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    pulse_start();
    pulse_tick();
    check("borrow_1000", disp(), 16'h0959);
    pulse_clear();

    // Reset mid-run
    press(4'd5); press(4'd2); press(4'd0);
    pulse_start();
    check("pre_rst_running", {15'd0, running}, 16'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_run_time", disp(), 16'h0000);
    check("rst_run_running", {15'd0, running}, 16'd0);
    check("rst_run_key_en_n", {15'd0, kp.key_en_n}, 16'd0);
    check("rst_run_done", {15'd0, done}, 16'd0);

    // Clear from PAUSE
    press(4'd3);
    pulse_start();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("pause2_key_en_n", {15'd0, kp.key_en_n}, 16'd1);
    pulse_clear();
    check("clear_pause_time", disp(), 16'h0000);
    check("clear_pause_key_en_n", {15'd0, kp.key_en_n}, 16'd0);
    check("clear_pause_running", {15'd0, running}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_entry_countdown.md
# time_entry_countdown

Keypad time-entry and countdown core of the microwave. It sits directly downstream of the keypad encoder and consumes its BCD digit and active-low valid strobe. Digits are shifted into a four-digit MM:SS register. On start, the register counts down once per 1 Hz tick to 00:00, and the block drives the encoder enable so keys are locked while cooking.

## Interface
- SEC_WRAP_TENS, default 5: seconds-tens value loaded on a minute borrow (ones loaded with 9).
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- digit  in  4  BCD key code from encoder; meaningful only while dv=0.
- dv  in  1  encoder valid, active-low (0 = valid key held); already synchronous to clk.
- start  in  1  start/resume request, level sampled each cycle.
- pause  in  1  pause request.
- clear  in  1  cancel/clear request.
- tick  in  1  one-cycle 1 Hz enable.
- min_t, min_o, sec_t, sec_o  out  4 each  displayed BCD time.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on reaching 00:00.
- key_en_n  out  1  encoder enable, active-low; 0 only in ENTRY.

## Operation
- States: ENTRY, RUN, PAUSE. Reset → ENTRY.
- Reset values: all digits 0, running 0, done 0, key_en_n 0, dv_q 1.
- Key edge: dv_q is dv registered. key_hit = (dv==0 && dv_q==1). A held key produces exactly one hit.
- Digits with value >9 are ignored (no shift).
- Request priority in every state: clear > pause > start. At most one action per cycle.
- ENTRY:
  - clear → all digits 0.
  - else start and time≠0000 → RUN. A key_hit in the same cycle is dropped.
  - else start with time=0000 → no effect.
  - else key_hit → shift left: min_t←min_o, min_o←sec_t, sec_t←sec_o, sec_o←digit. The old min_t is lost.
  - pause and tick have no effect.
- RUN:
  - clear → ENTRY, digits 0.
  - else pause → PAUSE. A tick in the same cycle is lost.
  - else tick → decrement.
  - Keys ignored.
- PAUSE:
  - clear → ENTRY, digits 0.
  - else start → RUN.
  - Ticks and keys ignored.
- Decrement rules (BCD):
  - sec_o>0 → sec_o−1.
  - else sec_t>0 → sec_t−1, sec_o=9.
  - else minutes>0 → minutes decrement as 2-digit BCD, sec_t=SEC_WRAP_TENS, sec_o=9.
  - Seconds entered >59 (e.g. 0190) count down unchanged: 0190→0189…0100→0059.
- Completion: a decrement producing 0000 moves to ENTRY and asserts done.
- A running of 0000 is unreachable: start is refused at zero.
- On exit to ENTRY, dv_q is not reset. A key held across completion does not register until it is released and pressed again.

## Timing
- All outputs are registered. Digit shift is visible the cycle after the edge where key_hit is true.
- running and key_en_n change in the cycle after the state transition edge.
- done is high for exactly the one cycle following the edge that wrote 0000.
- Tick-to-display latency: 1 cycle.
- rst mid-RUN → next cycle ENTRY, 0000, done 0. A pending done pulse is cancelled.
- Back-to-back ticks on consecutive cycles each decrement.

## Structure
- Package microondas_pkg:
  - state enum (ENTRY, RUN, PAUSE);
  - bcd_t 4-bit typedef;
  - BCD_MAX=9 constant;
  - shared with the encoder/display blocks.
- Sub-module bcd_mmss_dec: combinational MM:SS BCD decrementer.
  - Inputs: four digits. Outputs: four digits plus is_zero (of the result).
  - Parameter: SEC_WRAP_TENS.
- The top holds the FSM, dv edge detector and digit register.

## Test plan
- Enter 1,3,0 (dv pulses low ~5 cycles each) → display 0130. Hold digit 7 with dv=0 for 20 cycles → exactly one shift.
- From 0130, start, apply 31 ticks → 0059 after the 31st tick. Running high throughout.
- Load 0002, start, 2 ticks → 0000 and done high for one cycle, then ENTRY with key_en_n=0.
- In RUN at 0045, assert pause and tick together → PAUSE, still 0045. Further ticks ignored; start resumes.
- Start with 0000 → stays ENTRY. Start and key_hit same cycle at 0005 → RUN, display 0005.
- rst asserted in RUN at 0520 → next cycle 0000, ENTRY, running 0. Clear in PAUSE → 0000, ENTRY.
